// File: rtl/lh_pkg.sv
// Shared types for the lighthouse pulse path: pulse record layout, frame byte index, byte mapping.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package lh_pkg;

    localparam int SENSOR_W    = 2;
    localparam int WIDTH_W     = 16;
    localparam int TS_W        = 24;
    localparam int FRAME_BYTES = 6;
    localparam int REC_W       = SENSOR_W + WIDTH_W + TS_W;   // 42 bits

    typedef struct packed {
        logic [SENSOR_W-1:0] sensor;
        logic [WIDTH_W-1:0]  width;
        logic [TS_W-1:0]     ts;
    } pulse_rec_t;

    typedef enum logic [2:0] {
        BYTE0 = 3'd0,
        BYTE1 = 3'd1,
        BYTE2 = 3'd2,
        BYTE3 = 3'd3,
        BYTE4 = 3'd4,
        BYTE5 = 3'd5
    } byte_idx_t;

    // Frame layout, MSB first: sensor, width hi/lo, timestamp hi/mid/lo.
    function automatic logic [7:0] frame_byte(input pulse_rec_t rec, input byte_idx_t idx);
        logic [7:0] b;
        case (idx)
            BYTE0:   b = {6'b0, rec.sensor};
            BYTE1:   b = rec.width[15:8];
            BYTE2:   b = rec.width[7:0];
            BYTE3:   b = rec.ts[23:16];
            BYTE4:   b = rec.ts[15:8];
            BYTE5:   b = rec.ts[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic byte_idx_t next_idx(input byte_idx_t idx);
        byte_idx_t n;
        case (idx)
            BYTE0:   n = BYTE1;
            BYTE1:   n = BYTE2;
            BYTE2:   n = BYTE3;
            BYTE3:   n = BYTE4;
            BYTE4:   n = BYTE5;
            default: n = BYTE0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with registered level; head data is visible combinationally from storage.
// Latency: a pushed entry is at the head one cycle after the push into an empty FIFO.
// Backpressure: push ignored when full unless popped in the same cycle; pop ignored when empty.
// Ports: clk/rst (sync, active-high), push/push_dat, pop/head_dat, full, empty, level.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 42
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == (AW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pulse_packetizer.sv
// Buffers pulse records and serialises each into a 6-byte frame on a valid/ready byte stream.
// Latency: valid_tx rises one cycle after a write into an empty FIFO; back-to-back frames have no bubble.
// Backpressure: ready_tx stalls the byte stream; pulse input cannot stall, so records arriving when full are dropped and counted.
// Ports: clk/rst (sync, active-high); pulse_valid/sensor/width/ts in; n_cs (synchronised);
//        data_tx/valid_tx/ready_tx byte stream; fifo_level, overflow (sticky), drop_count (saturating).
module pulse_packetizer #(
    parameter int DEPTH   = 8,
    parameter int TS_W    = 24,
    parameter int WIDTH_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pulse_valid,
    input  logic [1:0]              pulse_sensor,
    input  logic [WIDTH_W-1:0]      pulse_width,
    input  logic [TS_W-1:0]         pulse_ts,
    input  logic                    n_cs,
    output logic [7:0]              data_tx,
    output logic                    valid_tx,
    input  logic                    ready_tx,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    import lh_pkg::*;

    pulse_rec_t   in_rec;
    pulse_rec_t   head_rec;
    logic [REC_W-1:0] head_bits;
    logic         fifo_full;
    logic         fifo_empty;
    byte_idx_t    idx;
    logic         ncs_q;
    logic         hs;
    logic         abort;
    logic         adv;
    logic         pop;
    logic         push;
    logic         drop;

    assign in_rec   = '{sensor: pulse_sensor, width: pulse_width, ts: pulse_ts};
    assign head_rec = pulse_rec_t'(head_bits);

    assign valid_tx = !fifo_empty;
    assign data_tx  = valid_tx ? frame_byte(head_rec, idx) : 8'h00;

    assign hs    = valid_tx && ready_tx;
    // Chip-select released mid-frame: rewind so the head record is resent whole.
    assign abort = n_cs && !ncs_q && (idx != BYTE0);
    assign adv   = hs && !abort;
    assign pop   = adv && (idx == BYTE5);
    assign push  = pulse_valid && (!fifo_full || pop);
    assign drop  = pulse_valid && fifo_full && !pop;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (in_rec),
        .pop      (pop),
        .head_dat (head_bits),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= BYTE0;
            ncs_q      <= 1'b1;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            ncs_q <= n_cs;
            if (abort) begin
                idx <= BYTE0;
            end else if (adv) begin
                idx <= next_idx(idx);
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pulse_packetizer.sv
// Directed bench for pulse_packetizer: table of records with hand-computed frames plus corner sequences.
// Latency: not applicable.
// Backpressure: exercised via ready_tx hold-off and n_cs abort.
module tb_pulse_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pulse_valid;
    logic [1:0]  pulse_sensor;
    logic [15:0] pulse_width;
    logic [23:0] pulse_ts;
    logic        n_cs;
    logic [7:0]  data_tx;
    logic        valid_tx;
    logic        ready_tx;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  s;
        logic [15:0] w;
        logic [23:0] t;
        logic [47:0] exp;
    } vec_t;

    vec_t vec [10];

    pulse_packetizer #(.DEPTH(8), .TS_W(24), .WIDTH_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pulse_valid  (pulse_valid),
        .pulse_sensor (pulse_sensor),
        .pulse_width  (pulse_width),
        .pulse_ts     (pulse_ts),
        .n_cs         (n_cs),
        .data_tx      (data_tx),
        .valid_tx     (valid_tx),
        .ready_tx     (ready_tx),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_rec(input int i);
        pulse_valid  = 1'b1;
        pulse_sensor = vec[i].s;
        pulse_width  = vec[i].w;
        pulse_ts     = vec[i].t;
        tick();
        pulse_valid  = 1'b0;
    endtask

    // Consumes n bytes (ready_tx must be high); gaps counts cycles spent waiting for valid_tx.
    task automatic recv_bytes(input logic [47:0] exp, input int n, input string name, output int gaps);
        gaps = 0;
        for (int b = 0; b < n; b++) begin
            int wt = 0;
            while (!valid_tx && wt < 50) begin
                tick();
                wt++;
                gaps++;
            end
            if (!valid_tx) begin
                check($sformatf("%s timeout b%0d", name, b), 64'(valid_tx), 64'd1);
                return;
            end
            check($sformatf("%s b%0d", name, b), 64'(data_tx), 64'(exp[47-8*b -: 8]));
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        vec[0] = '{2'd2, 16'h1234, 24'hABCDEF, 48'h021234ABCDEF};
        vec[1] = '{2'd1, 16'h00FF, 24'h000001, 48'h0100FF000001};
        vec[2] = '{2'd3, 16'hBEEF, 24'h123456, 48'h03BEEF123456};
        vec[3] = '{2'd0, 16'h8001, 24'hFFFFFF, 48'h008001FFFFFF};
        vec[4] = '{2'd1, 16'h0A0B, 24'h0C0D0E, 48'h010A0B0C0D0E};
        vec[5] = '{2'd2, 16'hFFFF, 24'h000000, 48'h02FFFF000000};
        vec[6] = '{2'd3, 16'h5A5A, 24'hA5A5A5, 48'h035A5AA5A5A5};
        vec[7] = '{2'd0, 16'h0001, 24'h800000, 48'h000001800000};
        vec[8] = '{2'd2, 16'hC0DE, 24'hF00D42, 48'h02C0DEF00D42};
        vec[9] = '{2'd1, 16'h7777, 24'h010203, 48'h017777010203};

        rst = 1'b1; pulse_valid = 1'b0; pulse_sensor = '0; pulse_width = '0; pulse_ts = '0;
        n_cs = 1'b0; ready_tx = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst valid_tx", 64'(valid_tx), 64'd0);
        check("rst data_tx", 64'(data_tx), 64'd0);
        check("rst level", 64'(fifo_level), 64'd0);
        check("rst overflow", 64'(overflow), 64'd0);
        check("rst drop_count", 64'(drop_count), 64'd0);

        // Single record, stall then stream
        push_rec(0);
        check("t1 level", 64'(fifo_level), 64'd1);
        check("t1 valid", 64'(valid_tx), 64'd1);
        check("t1 b0 early", 64'(data_tx), 64'h02);
        tick(); tick();
        check("t1 stall valid", 64'(valid_tx), 64'd1);
        check("t1 stall data", 64'(data_tx), 64'h02);
        ready_tx = 1'b1;
        recv_bytes(vec[0].exp, 6, "t1", gaps);
        check("t1 gaps", 64'(gaps), 64'd0);
        check("t1 valid after", 64'(valid_tx), 64'd0);
        check("t1 level after", 64'(fifo_level), 64'd0);

        // Two back-to-back frames, no bubble
        ready_tx = 1'b0;
        push_rec(1);
        push_rec(2);
        check("t2 level", 64'(fifo_level), 64'd2);
        ready_tx = 1'b1;
        recv_bytes(vec[1].exp, 6, "t2 f0", gaps);
        check("t2 f0 gaps", 64'(gaps), 64'd0);
        recv_bytes(vec[2].exp, 6, "t2 f1", gaps);
        check("t2 f1 gaps", 64'(gaps), 64'd0);
        check("t2 valid after", 64'(valid_tx), 64'd0);

        // Table: 10 writes into depth 8 with ready low, then drain
        ready_tx = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_rec(i);
            check($sformatf("t3 level %0d", i), 64'(fifo_level), 64'(i < 8 ? i + 1 : 8));
            check($sformatf("t3 drops %0d", i), 64'(drop_count), 64'(i < 8 ? 0 : i - 7));
        end
        check("t3 overflow", 64'(overflow), 64'd1);
        ready_tx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            recv_bytes(vec[i].exp, 6, $sformatf("t3 f%0d", i), gaps);
            check($sformatf("t3 f%0d gaps", i), 64'(gaps), 64'd0);
        end
        check("t3 valid after", 64'(valid_tx), 64'd0);

        // Abort after 3 bytes; handshake in the abort cycle is ignored
        ready_tx = 1'b0;
        push_rec(2);
        ready_tx = 1'b1;
        recv_bytes(vec[2].exp, 3, "t4 part", gaps);
        check("t4 b3 pending", 64'(data_tx), 64'h12);
        n_cs = 1'b1;
        tick();
        check("t4 abort data", 64'(data_tx), 64'h03);
        check("t4 abort valid", 64'(valid_tx), 64'd1);
        check("t4 abort level", 64'(fifo_level), 64'd1);
        n_cs = 1'b0; ready_tx = 1'b0;
        tick();
        check("t4 idle data", 64'(data_tx), 64'h03);
        ready_tx = 1'b1;
        recv_bytes(vec[2].exp, 6, "t4 resend", gaps);
        check("t4 valid after", 64'(valid_tx), 64'd0);
        check("t4 level after", 64'(fifo_level), 64'd0);

        // Full FIFO, write coincides with b5 handshake
        ready_tx = 1'b0;
        for (int i = 0; i < 8; i++) push_rec(i);
        check("t5 level full", 64'(fifo_level), 64'd8);
        ready_tx = 1'b1;
        recv_bytes(vec[0].exp, 5, "t5 part", gaps);
        check("t5 b5 pending", 64'(data_tx), 64'hEF);
        push_rec(8);
        check("t5 level", 64'(fifo_level), 64'd8);
        check("t5 drops", 64'(drop_count), 64'd2);
        for (int i = 1; i < 9; i++) begin
            recv_bytes(vec[i].exp, 6, $sformatf("t5 f%0d", i), gaps);
        end
        check("t5 valid after", 64'(valid_tx), 64'd0);

        // Reset mid-frame with 4 records stored
        ready_tx = 1'b0;
        for (int i = 4; i < 8; i++) push_rec(i);
        check("t6 level pre", 64'(fifo_level), 64'd4);
        ready_tx = 1'b1;
        recv_bytes(vec[4].exp, 2, "t6 part", gaps);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6 valid", 64'(valid_tx), 64'd0);
        check("t6 level", 64'(fifo_level), 64'd0);
        check("t6 drops", 64'(drop_count), 64'd0);
        check("t6 overflow", 64'(overflow), 64'd0);
        ready_tx = 1'b0;
        push_rec(1);
        check("t6 new level", 64'(fifo_level), 64'd1);
        ready_tx = 1'b1;
        recv_bytes(vec[1].exp, 6, "t6 new", gaps);
        check("t6 valid after", 64'(valid_tx), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
